// File: rtl/cpu_bus_pkg.sv
// Shared IF-to-ID bus definitions: bundle width, field offsets and the reset PC.
package cpu_bus_pkg;

  localparam int IF2ID_BUS_W = 100;

  localparam int PC_LSB    = 0;
  localparam int INST_LSB  = 32;
  localparam int ADEF_BIT  = 64;
  localparam int TLBR_BIT  = 65;
  localparam int PIF_BIT   = 66;
  localparam int PPI_BIT   = 67;
  localparam int BADDR_LSB = 68;

  localparam logic [31:0] RESET_PC = 32'h1bfffffc;

  typedef struct packed {
    logic [31:0] ex_baddr;
    logic        ex_ppi;
    logic        ex_pif;
    logic        ex_tlbr;
    logic        ex_adef;
    logic [31:0] inst;
    logic [31:0] pc;
  } if2id_bus_t;

  function automatic logic [31:0] bus_pc(input logic [IF2ID_BUS_W-1:0] bus);
    return bus[PC_LSB +: 32];
  endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Pointer/occupancy control for inst_queue: push/pop/flush arbitration,
// wrapping read/write pointers and the entry count.
module iq_ptr_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_in_valid,
  input  logic             i_out_allowin,
  input  logic             i_flush,
  input  logic             i_bypass_go,
  output logic             o_push,
  output logic [PTR_W-1:0] o_wr_ptr,
  output logic [PTR_W-1:0] o_rd_ptr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_allowin
);

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] w_wr_ptr_nx, w_rd_ptr_nx;
  logic [CNT_W-1:0] w_count_nx;
  logic             w_not_empty, w_push, w_pop;

  // allowin comes from registered count only: a pop while full does not open a slot
  assign o_allowin   = (r_count != CNT_W'(DEPTH));
  assign w_not_empty = (r_count != {CNT_W{1'b0}});
  assign w_push      = i_in_valid & o_allowin & ~i_flush & ~i_bypass_go;
  assign w_pop       = w_not_empty & i_out_allowin & ~i_flush;

  // Next-state pointer and count computation
  always_comb begin
    w_wr_ptr_nx = r_wr_ptr;
    w_rd_ptr_nx = r_rd_ptr;
    w_count_nx  = r_count;
    if (i_flush) begin
      w_wr_ptr_nx = {PTR_W{1'b0}};
      w_rd_ptr_nx = {PTR_W{1'b0}};
      w_count_nx  = {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        w_wr_ptr_nx = r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        w_wr_ptr_nx = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nx = r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
        w_rd_ptr_nx = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nx = r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   w_count_nx = r_count - {{(CNT_W-1){1'b0}}, 1'b1};
        default: w_count_nx = r_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      r_wr_ptr <= w_wr_ptr_nx;
      r_rd_ptr <= w_rd_ptr_nx;
      r_count  <= w_count_nx;
    end
  end

  assign o_push   = w_push;
  assign o_wr_ptr = r_wr_ptr;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;

endmodule

// File: rtl/inst_queue.sv
// IF-to-ID decoupling instruction FIFO with flush. Define INST_QUEUE_BYPASS_EN
// for a zero-latency path from in_bus to out_bus when the queue is empty.
module inst_queue
  import cpu_bus_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BUS_W = IF2ID_BUS_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [BUS_W-1:0]           in_bus,
  output logic                       iq_allowin,
  output logic                       out_valid,
  output logic [BUS_W-1:0]           out_bus,
  input  logic                       out_allowin,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     iq_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [BUS_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] w_wr_ptr, w_rd_ptr;
  logic [CNT_W-1:0] w_count;
  logic             w_push, w_bypass_go, w_empty;

  assign w_empty = (w_count == {CNT_W{1'b0}});

  iq_ptr_ctrl #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W),
    .CNT_W (CNT_W)
  ) u_ptr_ctrl (
    .clk           (clk),
    .reset         (reset),
    .i_in_valid    (in_valid),
    .i_out_allowin (out_allowin),
    .i_flush       (flush),
    .i_bypass_go   (w_bypass_go),
    .o_push        (w_push),
    .o_wr_ptr      (w_wr_ptr),
    .o_rd_ptr      (w_rd_ptr),
    .o_count       (w_count),
    .o_allowin     (iq_allowin)
  );

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_ptr] <= in_bus;
    end
  end

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue hands the incoming bundle straight to ID; it is stored only if ID stalls
  assign w_bypass_go = w_empty & in_valid & out_allowin & ~flush;
  assign out_valid   = w_empty ? (in_valid & ~flush) : 1'b1;
  assign out_bus     = w_empty ? in_bus : r_mem[w_rd_ptr];
`else
  assign w_bypass_go = 1'b0;
  assign out_valid   = ~w_empty;
  assign out_bus     = r_mem[w_rd_ptr];
`endif

  assign iq_count = w_count;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed test-plan steps followed by
// random traffic, all checked against a queue-based reference model.
module tb_inst_queue;
  import cpu_bus_pkg::*;

  localparam int DEPTH = 4;
  localparam int BUS_W = IF2ID_BUS_W;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic [BUS_W-1:0] in_bus = '0;
  logic             iq_allowin;
  logic             out_valid;
  logic [BUS_W-1:0] out_bus;
  logic             out_allowin = 1'b0;
  logic             flush = 1'b0;
  logic [2:0]       iq_count;

  int n_pass = 0;
  int n_total = 0;
  logic [BUS_W-1:0] model_q[$];

  inst_queue #(.DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bus      (in_bus),
    .iq_allowin  (iq_allowin),
    .out_valid   (out_valid),
    .out_bus     (out_bus),
    .out_allowin (out_allowin),
    .flush       (flush),
    .iq_count    (iq_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] pc);
    if2id_bus_t b;
    b          = '0;
    b.pc       = pc;
    b.inst     = pc ^ 32'h5a5a_0000;
    b.ex_baddr = 32'h0000_0000;
    return b;
  endfunction

  // Inputs are already driven (posedge+1); sample at posedge+4, update model, advance.
  task automatic step(input bit do_chk);
    logic             exp_valid;
    logic [BUS_W-1:0] exp_bus;
    bit               pu, pp;
    int               sz;
    #3;
    sz = model_q.size();
    if (do_chk) begin
`ifdef INST_QUEUE_BYPASS_EN
      exp_valid = (sz != 0) || (in_valid && !flush);
      exp_bus   = (sz != 0) ? model_q[0] : in_bus;
`else
      exp_valid = (sz != 0);
      exp_bus   = (sz != 0) ? model_q[0] : '0;
`endif
      chk("out_valid", {99'd0, out_valid}, {99'd0, exp_valid});
      chk("iq_allowin", {99'd0, iq_allowin}, {99'd0, (sz != DEPTH)});
      chk("iq_count", {97'd0, iq_count}, BUS_W'(sz));
      if (exp_valid) chk("out_bus", out_bus, exp_bus);
    end
    if (reset || flush) begin
      model_q.delete();
    end else begin
      pp = (sz > 0) && out_allowin;
      pu = in_valid && (sz < DEPTH);
`ifdef INST_QUEUE_BYPASS_EN
      if (sz == 0 && in_valid && out_allowin) pu = 1'b0;
`endif
      if (pp) void'(model_q.pop_front());
      if (pu) model_q.push_back(in_bus);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic oa, input logic fl);
    in_valid    = iv;
    in_bus      = mk(pc);
    out_allowin = oa;
    flush       = fl;
  endtask

  initial begin
    logic [BUS_W-1:0] adef_bus;
    logic [31:0]      pcv;

    // reset, then idle
    reset = 1'b1;
    step(1'b0);
    step(1'b1);
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1);
    step(1'b1);

    // fill to full, try a fifth push, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h1c00_0000 + 32'(i * 4), 1'b0, 1'b0);
      step(1'b1);
    end
    drive(1'b1, 32'h1c00_0010, 1'b0, 1'b0);
    step(1'b1);
    drive(1'b1, 32'h1c00_0010, 1'b1, 1'b0);
    step(1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1);

    // steady push+pop at count 2, wraps pointers
    drive(1'b1, 32'h1c00_1000, 1'b0, 1'b0);
    step(1'b1);
    drive(1'b1, 32'h1c00_1004, 1'b0, 1'b0);
    step(1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1c00_1008 + 32'(i * 4), 1'b1, 1'b0);
      step(1'b1);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);

    // 3 queued, flush with an in-flight push, then pc 1c008000 first out
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1c00_2000 + 32'(i * 4), 1'b0, 1'b0);
      step(1'b1);
    end
    drive(1'b1, 32'h1c00_200c, 1'b1, 1'b1);
    step(1'b1);
    chk("flush_count", {97'd0, iq_count}, '0);
    chk("flush_valid", {99'd0, out_valid}, '0);
    drive(1'b1, 32'h1c00_8000, 1'b0, 1'b0);
    step(1'b1);
    chk("after_flush_pc", {68'd0, bus_pc(out_bus)}, {68'd0, 32'h1c00_8000});
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1);
    step(1'b1);

    // exception-flagged entry passes unchanged
    adef_bus = mk(32'h1c00_0002);
    adef_bus[ADEF_BIT] = 1'b1;
    adef_bus[BADDR_LSB +: 32] = 32'h1c00_0002;
    in_valid = 1'b1; in_bus = adef_bus; out_allowin = 1'b0; flush = 1'b0;
    step(1'b1);
    chk("adef_bit", {99'd0, out_bus[ADEF_BIT]}, {99'd0, 1'b1});
    chk("adef_baddr", {68'd0, out_bus[99:68]}, {68'd0, 32'h1c00_0002});
    drive(1'b1, 32'h1c00_3000, 1'b0, 1'b0);
    step(1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    chk("reset_drop", {99'd0, out_valid}, '0);
    step(1'b1);

    // empty queue, push with ID ready: bypass shows it now, else next cycle
    drive(1'b1, 32'h1c00_0010, 1'b1, 1'b0);
    step(1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1);

    // random traffic
    pcv = 32'h1c01_0000;
    for (int i = 0; i < 400; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_bus      = {$urandom(), $urandom(), $urandom(), 4'($urandom())};
      in_bus[31:0] = pcv;
      out_allowin = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      reset       = ($urandom_range(0, 79) == 0);
      pcv         = pcv + 32'd4;
      step(1'b1);
    end
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Decoupling instruction buffer between the fetch stage (IF) and the decode stage (ID).
- Each entry holds the 100-bit IF-to-ID bundle: {ex_baddr[31:0], ex_ppi, ex_pif, ex_tlbr, ex_adef, inst[31:0], pc[31:0]}.
- Absorbs ID back-pressure so IF can keep issuing inst_sram requests. Discards all wrong-path entries on an exception/ertn flush or a taken branch.

Parameters:
- DEPTH, 4, number of entries; must be a power of 2, at least 2.
- BUS_W, 100, entry width in bits; equals the IF-to-ID bus width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  IF_to_ID_valid from IF.
- in_bus  in  BUS_W  IF_to_ID_bus from IF.
- iq_allowin  out  1  to IF as ID_allowin; high when the queue can accept a push this cycle.
- out_valid  out  1  to ID; the head entry is valid.
- out_bus  out  BUS_W  head entry to ID.
- out_allowin  in  1  ID allowin; pops the head when out_valid is also high.
- flush  in  1  OR of exec_flush and the ID-resolved taken branch; discards all entries.
- iq_count  out  $clog2(DEPTH)+1  current occupancy, for debug/perf.

Behaviour:
- Storage: DEPTH x BUS_W register array; wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- push = in_valid & iq_allowin & ~flush.
- pop = out_valid & out_allowin & ~flush.
- iq_allowin = (count != DEPTH). It is derived from registered state only, with no combinational path from out_allowin.
  - When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0); out_bus = mem[rd_ptr].
- Minimum latency, in_bus to out_bus: 1 cycle.
- Order: strict FIFO. Entries carrying exception flags (adef/tlbr/pif/ppi) pass through unchanged; the queue never inspects them.
- Push only: mem[wr_ptr] <= in_bus, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (legal when 0 < count < DEPTH): both pointers advance and count is unchanged.
- Flush (highest priority, below reset):
  - wr_ptr, rd_ptr and count go to 0 next cycle.
  - Any push or pop that cycle is suppressed.
  - out_valid is 0 in the following cycle.
  - Memory contents are don't-care.
- Flush while empty: no effect beyond holding the pointers at 0.
- Reset: wr_ptr=0, rd_ptr=0, count=0, giving out_valid=0, iq_allowin=1 and iq_count=0. A reset mid-operation drops all entries identically.
- out_bus is don't-care while out_valid=0. The bench must not check it then.
- No X on control outputs after reset.

Optional Feature:
- Macro: INST_QUEUE_BYPASS_EN.
- Defined:
  - When count==0 and in_valid, out_valid=1 and out_bus=in_bus combinationally.
  - If out_allowin is also high and flush is low, the entry goes straight to ID, is not written, and count stays 0.
  - If out_allowin is low, the entry is written normally.
  - Zero-cycle latency when empty.
  - flush still forces out_valid=0 combinationally in the bypass case.
- Not defined: out_valid depends only on count; latency is always at least 1 cycle.

Decomposition:
- Shared package (cpu_bus_pkg):
  - IF2ID_BUS_W=100.
  - Field offsets PC_LSB=0, INST_LSB=32, ADEF_BIT=64, TLBR_BIT=65, PIF_BIT=66, PPI_BIT=67, BADDR_LSB=68.
  - Reset PC constant 32'h1bfffffc, reused by IF.
- One natural sub-module, iq_ptr_ctrl: pointers, count, push/pop/flush arbitration.
- Storage array and bypass mux stay in inst_queue.

Test Plan:
- Reset, then idle: out_valid=0, iq_allowin=1, iq_count=0.
- Push pc=1c000000,1c000004,1c000008,1c00000c with out_allowin=0: iq_count=4, iq_allowin=0. A fifth push with in_valid=1 is not accepted (IF must hold). Then out_allowin=1 yields the pcs in order, one per cycle.
- Continuous push and pop at count=2 for 10 cycles: iq_count stays 2, pcs leave in order, and the pointers wrap past DEPTH-1 correctly.
- 3 entries queued, flush=1 with in_valid=1 in the same cycle: next cycle iq_count=0 and out_valid=0. The in-flight entry is lost, and the next push (pc=1c008000) is the first output.
- Entry with adef=1 and baddr=1c000002: it appears on out_bus with bits 64 and 99:68 intact. Reset asserted with 2 entries queued gives out_valid=0 next cycle.
- With INST_QUEUE_BYPASS_EN, empty queue, push pc=1c000010 with out_allowin=1: out_valid is high the same cycle with the matching out_bus, and iq_count stays 0. Without the macro, the entry appears one cycle later.
